// File: rtl/alu_op_arbiter.sv
// Two-requester front end for a single shared ALU.
// A round-robin grant picks one request in IDLE, EXEC evaluates it into a
// result register, and RESP holds the tagged result until the sink takes it.
module alu_op_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               rr_last_q, rr_last_d;
  logic               id_q, id_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               grant_id;
  logic               any_valid;
  logic [WIDTH-1:0]   alu_res;

  // Grant selection: on a tie the requester not served last wins,
  // a lone requester always wins.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant_id   = (req0_valid && req1_valid) ? ~rr_last_q : req1_valid;
    req0_ready = (state_q == IDLE) && req0_valid && !grant_id;
    req1_ready = (state_q == IDLE) && req1_valid && grant_id;
  end

  // ALU datapath on the latched operands; reserved opcodes produce zero.
  always_comb begin
    alu_res = '0;
    case (op_q)
      3'd0:    alu_res = a_q + b_q;
      3'd1:    alu_res = a_q - b_q;
      3'd2:    alu_res = a_q & b_q;
      3'd3:    alu_res = a_q | b_q;
      3'd4:    alu_res = a_q ^ b_q;
      3'd5:    alu_res = (a_q > b_q) ? '1 : '0;
      default: alu_res = '0;
    endcase
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    id_d      = id_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        // Any valid requester is granted and therefore accepted this cycle.
        if (any_valid) begin
          id_d    = grant_id;
          op_d    = grant_id ? req1_op : req0_op;
          a_d     = grant_id ? req1_a  : req0_a;
          b_d     = grant_id ? req1_b  : req0_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_res;
        err_d   = op_q[2] & op_q[1];
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rr_last_d = id_q;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      id_q      <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed plus randomized bench for alu_op_arbiter against a transaction-level model.
module tb_alu_op_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [3:0] rsp_data;
  logic [7:0] op_count;

  int tests = 0;
  int fails = 0;
  int n_ops = 0;
  int cnt_model = 0;
  bit last_id = 1'b1;

  alu_op_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU written from the opcode table with plain integer arithmetic.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int d, output int e);
    e = 0;
    case (op)
      0: d = (a + b) % 16;
      1: d = (a - b + 16) % 16;
      2: d = a & b;
      3: d = a | b;
      4: d = a ^ b;
      5: d = (a > b) ? 15 : 0;
      default: begin d = 0; e = 1; end
    endcase
  endfunction

  // One complete request/response transaction; hold = cycles the sink stalls.
  task automatic transact(input bit v0, input bit v1,
                          input logic [2:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                          input logic [2:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                          input int hold);
    int eid, ed, ee;
    int eo, ea, eb;
    eid = (v0 && v1) ? (last_id ? 0 : 1) : (v1 ? 1 : 0);
    eo  = eid ? int'(o1) : int'(o0);
    ea  = eid ? int'(a1) : int'(a0);
    eb  = eid ? int'(b1) : int'(b0);
    ref_alu(eo, ea, eb, ed, ee);

    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready  = 1'b0;
    #1;
    chk("idle_ready0", 32'(req0_ready), 32'(v0 && eid == 0));
    chk("idle_ready1", 32'(req1_ready), 32'(v1 && eid == 1));
    tick;
    // Accepted: EXEC. Scramble payloads; only the accepted values may matter.
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    req0_op = 3'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_op = 3'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
    #1;
    chk("exec_ready0", 32'(req0_ready), 32'd0);
    chk("exec_ready1", 32'(req1_ready), 32'd0);
    tick;
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_id", 32'(rsp_id), 32'(eid));
    chk("resp_data", 32'(rsp_data), 32'(ed));
    chk("resp_err", 32'(rsp_err), 32'(ee));
    chk("resp_ready0", 32'(req0_ready), 32'd0);
    chk("resp_ready1", 32'(req1_ready), 32'd0);
    chk("resp_count", 32'(op_count), 32'(cnt_model));
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", 32'(rsp_data), 32'(ed));
      chk("hold_id", 32'(rsp_id), 32'(eid));
      chk("hold_err", 32'(rsp_err), 32'(ee));
      chk("hold_count", 32'(op_count), 32'(cnt_model));
      chk("hold_ready0", 32'(req0_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick;
    rsp_ready = 1'b0;
    if (cnt_model < 255) cnt_model++;
    last_id = (eid == 1);
    n_ops++;
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_count", 32'(op_count), 32'(cnt_model));
    $display("[TB] op %0d: id=%0d opcode=%0d a=%h b=%h data=%h err=%0d count=%0d",
             n_ops, eid, eo, ea, eb, ed, ee, cnt_model);
  endtask

  initial begin
    bit v0, v1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);

    // Reset while EXEC: op discarded, no response, count not bumped.
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 4'd1; req1_b = 4'd1;
    #1;
    chk("pre_rst_ready1", 32'(req1_ready), 32'd1);
    tick;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    req1_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("exec_rst_busy", 32'(busy), 32'd0);
    chk("exec_rst_valid", 32'(rsp_valid), 32'd0);
    chk("exec_rst_count", 32'(op_count), 32'd0);
    tick;
    chk("exec_rst_valid2", 32'(rsp_valid), 32'd0);
    last_id = 1'b1;
    cnt_model = 0;

    // Directed operations.
    transact(1, 0, 3'd0, 4'd9, 4'd8, 3'd0, 4'd0, 4'd0, 0);  // ADD 9+8 -> 1
    transact(0, 1, 3'd0, 4'd0, 4'd0, 3'd1, 4'd2, 4'd5, 0);  // SUB 2-5 -> D
    transact(1, 0, 3'd5, 4'd5, 4'd3, 3'd0, 4'd0, 4'd0, 0);  // GT -> F
    transact(0, 1, 3'd0, 4'd0, 4'd0, 3'd5, 4'd3, 4'd3, 0);  // GT equal -> 0
    // Both valid: alternating ids.
    transact(1, 1, 3'd2, 4'hC, 4'hA, 3'd3, 4'h5, 4'h2, 0);
    transact(1, 1, 3'd4, 4'hF, 4'h3, 3'd3, 4'h8, 4'h1, 0);
    transact(1, 1, 3'd0, 4'h7, 4'h7, 3'd1, 4'h0, 4'h1, 0);
    transact(1, 1, 3'd2, 4'h6, 4'h3, 3'd4, 4'h9, 4'h9, 0);
    // Sink stall in RESP.
    transact(1, 0, 3'd3, 4'h4, 4'h1, 3'd0, 4'h0, 4'h0, 5);
    // Reserved opcode then a normal one.
    transact(0, 1, 3'd0, 4'h0, 4'h0, 3'd7, 4'hF, 4'hF, 0);
    transact(0, 1, 3'd0, 4'h0, 4'h0, 3'd0, 4'h3, 4'h4, 0);

    // Randomized traffic, long enough to saturate the counter.
    for (int k = 0; k < 250; k++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      transact(v0, v1, 3'($urandom), 4'($urandom), 4'($urandom),
               3'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 2)));
    end
    chk("count_saturated", 32'(op_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
